// File: rtl/mem_bist_pkg.sv
// Shared types and March C- phase tables for the memory BIST controller.
// Each per-phase table is a packed vector indexed by the phase number.
package mem_bist_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic [2:0] {
        PH_W0_UP,
        PH_R0W1_UP,
        PH_R1W0_UP,
        PH_R0W1_DN,
        PH_R1W0_DN,
        PH_R0_UP
    } phase_t;

    localparam int NUM_PHASES = 6;

    // Background selectors; a data word is the selector replicated across the bus.
    localparam logic BG0 = 1'b0;
    localparam logic BG1 = 1'b1;

    // Bit n of each table describes phase n (leftmost entry is phase 5).
    localparam logic [NUM_PHASES-1:0] PH_DOWN = 6'b011000;
    localparam logic [NUM_PHASES-1:0] PH_RD   = 6'b111110;
    localparam logic [NUM_PHASES-1:0] PH_WR   = 6'b011111;
    localparam logic [NUM_PHASES-1:0] PH_EXP  = {BG0, BG1, BG0, BG1, BG0, BG0};
    localparam logic [NUM_PHASES-1:0] PH_WVAL = {BG0, BG0, BG1, BG0, BG1, BG0};

endpackage

// File: rtl/mem_bist_if.sv
// Memory-side write/read port. The BIST controller is the master; the memory
// is the slave and returns combinational read data.
interface mem_bist_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_addr, output mem_we, output mem_wdata, input mem_rdata);
    modport slave  (input mem_addr, input mem_we, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/mem_bist_addr_gen.sv
// Loadable up/down address counter. o_tc flags the last address of a sweep
// in the current direction, so a phase never wraps.
module mem_bist_addr_gen #(
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_load_val,
    input  logic              i_step,
    input  logic              i_down,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_tc
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr <= '0;
        end else if (i_load) begin
            r_addr <= i_load_val;
        end else if (i_step) begin
            r_addr <= i_down ? (r_addr - ONE) : (r_addr + ONE);
        end
    end

    assign o_addr = r_addr;
    assign o_tc   = i_down ? (r_addr == '0) : (r_addr == '1);
endmodule

// File: rtl/mem_bist_ctrl.sv
// March C- BIST controller: sequences the six march elements over the memory,
// compares reads against the expected background, counts and captures failures.
import mem_bist_pkg::*;

module mem_bist_ctrl #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    mem_bist_if.master        mem,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        err_count,
    output logic [2:0]        fail_phase,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_exp,
    output logic [DATA_W-1:0] fail_got
);
    state_t            r_state, w_state_next;
    phase_t            r_phase, w_next_phase;
    logic              r_op;
    logic [7:0]        r_err;
    phase_t            r_fail_phase;
    logic [ADDR_W-1:0] r_fail_addr;
    logic [DATA_W-1:0] r_fail_exp, r_fail_got;

    logic              w_running, w_start, w_rd_en, w_wr_en, w_last_sub;
    logic              w_rd_cycle, w_wr_cycle, w_mismatch;
    logic              w_tc, w_phase_end, w_last_op, w_load, w_step;
    logic [ADDR_W-1:0] w_addr, w_load_val;
    logic [DATA_W-1:0] w_exp;

    assign w_running    = (r_state == RUN);
    assign w_start      = start && !w_running;
    assign w_rd_en      = PH_RD[r_phase];
    assign w_wr_en      = PH_WR[r_phase];
    // r_op marks the write half of a read-then-write pair at one address.
    assign w_last_sub   = !(w_rd_en && w_wr_en) || r_op;
    assign w_rd_cycle   = w_running && w_rd_en && !r_op;
    assign w_wr_cycle   = w_running && w_wr_en && (!w_rd_en || r_op);
    assign w_exp        = {DATA_W{PH_EXP[r_phase]}};
    assign w_mismatch   = w_rd_cycle && (mem.mem_rdata != w_exp);
    assign w_phase_end  = w_running && w_last_sub && w_tc;
    assign w_last_op    = w_phase_end && (r_phase == PH_R0_UP);
    assign w_next_phase = phase_t'(r_phase + 3'd1);
    assign w_load       = w_start || (w_phase_end && !w_last_op);
    assign w_load_val   = (!w_start && PH_DOWN[w_next_phase]) ? '1 : '0;
    assign w_step       = w_running && w_last_sub && !w_tc;

    mem_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_step     (w_step),
        .i_down     (PH_DOWN[r_phase]),
        .o_addr     (w_addr),
        .o_tc       (w_tc)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = RUN;
            RUN:     if (w_last_op) w_state_next = DONE;
            DONE:    if (start) w_state_next = RUN;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n || w_start) begin
            r_phase      <= PH_W0_UP;
            r_op         <= 1'b0;
            r_err        <= '0;
            r_fail_phase <= PH_W0_UP;
            r_fail_addr  <= '0;
            r_fail_exp   <= '0;
            r_fail_got   <= '0;
        end else if (w_running) begin
            r_op <= !w_last_sub;
            if (w_phase_end && !w_last_op) begin
                r_phase <= w_next_phase;
            end
            if (w_mismatch) begin
                if (r_err != 8'hFF) begin
                    r_err <= r_err + 8'd1;
                end
                // A zero count means this is the first mismatch of the run.
                if (r_err == 8'd0) begin
                    r_fail_phase <= r_phase;
                    r_fail_addr  <= w_addr;
                    r_fail_exp   <= w_exp;
                    r_fail_got   <= mem.mem_rdata;
                end
            end
        end
    end

    assign mem.mem_addr  = w_running ? w_addr : '0;
    assign mem.mem_we    = w_wr_cycle;
    assign mem.mem_wdata = w_wr_cycle ? {DATA_W{PH_WVAL[r_phase]}} : '0;

    assign busy       = w_running;
    assign done       = (r_state == DONE);
    assign pass       = done && (r_err == 8'd0);
    assign err_count  = r_err;
    assign fail_phase = r_fail_phase;
    assign fail_addr  = r_fail_addr;
    assign fail_exp   = r_fail_exp;
    assign fail_got   = r_fail_got;
endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Directed bench for mem_bist_ctrl against an 8x8 memory model with
// selectable faults: none, read returns mem[addr+1], or bit 3 of address 5 stuck at 0.
module tb_mem_bist_ctrl;
    import mem_bist_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [7:0] err_count;
    logic [2:0] fail_phase;
    logic [2:0] fail_addr;
    logic [7:0] fail_exp, fail_got;

    int n_checks = 0;
    int n_errors = 0;
    int cycles;
    int fault_mode = 0;

    always #5 clk = ~clk;

    mem_bist_if #(.ADDR_W(3), .DATA_W(8)) mif ();

    mem_bist_ctrl #(.ADDR_W(3), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mem        (mif),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_phase (fail_phase),
        .fail_addr  (fail_addr),
        .fail_exp   (fail_exp),
        .fail_got   (fail_got)
    );

    logic [7:0] mem_model [8];
    logic [2:0] addr_p1;
    logic [7:0] rd_val;

    always @(posedge clk) begin
        if (mif.mem_we) mem_model[mif.mem_addr] <= mif.mem_wdata;
    end

    always_comb begin
        addr_p1 = mif.mem_addr + 3'd1;
        rd_val  = mem_model[mif.mem_addr];
        if (fault_mode == 1) begin
            rd_val = mem_model[addr_p1];
        end else if (fault_mode == 2 && mif.mem_addr == 3'd5) begin
            rd_val = mem_model[5] & 8'hF7;
        end
    end
    assign mif.mem_rdata = rd_val;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse start, check the first cycle of the run, then count busy cycles.
    task automatic do_run(input string name, input bit repulse, output int cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({name, "_first_busy"}, busy, 1);
        check({name, "_first_done"}, done, 0);
        check({name, "_first_we"}, mif.mem_we, 1);
        check({name, "_first_addr"}, mif.mem_addr, 0);
        check({name, "_first_wdata"}, mif.mem_wdata, 0);
        check({name, "_first_err"}, err_count, 0);
        check({name, "_first_fail_addr"}, fail_addr, 0);
        check({name, "_first_fail_got"}, fail_got, 0);
        cyc = 0;
        while (busy === 1'b1 && cyc < 200) begin
            cyc++;
            start = repulse && (cyc == 10 || cyc == 40);
            @(negedge clk);
        end
        start = 1'b0;
        $display("run %s: busy_cycles=%0d done=%0b pass=%0b err_count=%0d fail_phase=%0d fail_addr=%0d fail_exp=%02h fail_got=%02h",
                 name, cyc, done, pass, err_count, fail_phase, fail_addr, fail_exp, fail_got);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_we", mif.mem_we, 0);
        check("rst_addr", mif.mem_addr, 0);
        check("rst_wdata", mif.mem_wdata, 0);
        check("rst_fail_phase", fail_phase, 0);
        check("rst_fail_exp", fail_exp, 0);
        reset_n = 1'b1;

        fault_mode = 0;
        do_run("clean", 1'b0, cycles);
        check("clean_cycles", cycles, 80);
        check("clean_done", done, 1);
        check("clean_pass", pass, 1);
        check("clean_err", err_count, 0);

        fault_mode = 1;
        do_run("addr_plus1", 1'b0, cycles);
        check("ap1_cycles", cycles, 80);
        check("ap1_done", done, 1);
        check("ap1_pass", pass, 0);
        check("ap1_err", err_count, 16);
        check("ap1_fail_phase", fail_phase, 1);
        check("ap1_fail_addr", fail_addr, 7);
        check("ap1_fail_exp", fail_exp, 8'h00);
        check("ap1_fail_got", fail_got, 8'hFF);

        // Restart straight from DONE with failures recorded.
        fault_mode = 0;
        do_run("restart_from_done", 1'b0, cycles);
        check("rfd_cycles", cycles, 80);
        check("rfd_pass", pass, 1);
        check("rfd_err", err_count, 0);

        fault_mode = 2;
        do_run("stuck_bit3_a5", 1'b0, cycles);
        check("stk_cycles", cycles, 80);
        check("stk_pass", pass, 0);
        check("stk_err", err_count, 2);
        check("stk_fail_phase", fail_phase, 2);
        check("stk_fail_addr", fail_addr, 5);
        check("stk_fail_exp", fail_exp, 8'hFF);
        check("stk_fail_got", fail_got, 8'hF7);

        fault_mode = 0;
        do_run("repulse", 1'b1, cycles);
        check("rep_cycles", cycles, 80);
        check("rep_pass", pass, 1);
        check("rep_err", err_count, 0);

        // Reset at cycle 30 of a faulty run, after one mismatch has been counted.
        fault_mode = 1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (29) @(negedge clk);
        check("mid_busy_before", busy, 1);
        check("mid_err_before", err_count, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_busy_after", busy, 0);
        check("mid_we_after", mif.mem_we, 0);
        check("mid_err_after", err_count, 0);
        check("mid_done_after", done, 0);
        reset_n = 1'b1;
        $display("run mid_reset: busy=%0b mem_we=%0b err_count=%0d", busy, mif.mem_we, err_count);

        fault_mode = 0;
        do_run("after_reset", 1'b0, cycles);
        check("ar_cycles", cycles, 80);
        check("ar_pass", pass, 1);

        // Start and reset together from DONE: reset must win.
        @(negedge clk); start = 1'b1; reset_n = 1'b0;
        @(negedge clk);
        check("both_busy", busy, 0);
        check("both_done", done, 0);
        check("both_we", mif.mem_we, 0);
        start = 1'b0; reset_n = 1'b1;
        $display("run start_with_reset: busy=%0b done=%0b", busy, done);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
